dff_bank_arbiter: RTL and testbench
===================================

Name: dff_bank_arbiter

Overview:
- Round-robin write arbiter in front of a small bank of asynchronous-reset D flip-flop registers.
- NREQ requesters share one write port into the bank; a 3-state FSM sequences arbitrate -> grant -> write.
- One combinational read port exposes the bank to the datapath.
- Used wherever several Lab 3 datapath units must share a register bank without write collisions.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, data width of each bank register
- AW, 2, address width; DEPTH = 2**AW registers

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- req  in  NREQ  per-requester write request, level
- wr_addr  in  NREQ*AW  flattened; requester i uses bits [i*AW +: AW]
- wr_data  in  NREQ*WIDTH  flattened; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot accept pulse, registered
- busy  out  1  high whenever FSM is not IDLE
- wr_done  out  1  one-cycle pulse after the bank write completes
- rd_addr  in  AW  read address
- rd_data  out  WIDTH  combinational bank[rd_addr]

Behaviour:
- Reset (async, rst=1): state=IDLE; gnt=0, busy=0, wr_done=0; rr_ptr=0; every bank register=0; the holding address/data/winner registers are cleared to 0. Outputs change immediately, without waiting for clk.
- FSM states: IDLE, GRANT, WRITE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, at the edge, select the winner as the first set req bit scanning from rr_ptr upward with wrap-around.
  - Capture the winner's wr_addr and wr_data into holding registers, set gnt[winner]=1, and go to GRANT.
- GRANT (1 cycle):
  - gnt one-hot high and busy=1.
  - The requester may drop req and change addr/data from the next edge; the captured values are used.
  - Next state is WRITE; gnt returns to 0.
- WRITE (1 cycle):
  - At the exiting edge, bank[hold_addr] <= hold_data.
  - wr_done=1 for the following cycle.
  - rr_ptr <= (winner+1) mod NREQ.
  - Next state is IDLE.
- Latency: req sampled at edge k -> gnt high after edge k -> bank updated and wr_done high after edge k+2.
- Maximum throughput: one write per 3 cycles.
- req changes during GRANT or WRITE are ignored until the FSM is back in IDLE.
- A requester holding req continuously is re-arbitrated normally; round-robin guarantees the others get a turn within NREQ grants.
- Simultaneous requests: exactly one grant; the others wait (no loss, provided they hold req).
- Two requesters targeting the same address are serialised; the later write wins.
- Read during write: rd_data shows the old value in the WRITE cycle and the new value after the edge.
- Reset mid-operation: the in-flight transaction is aborted, no bank write occurs, and wr_done is not pulsed.
- busy=1 in GRANT and WRITE, 0 in IDLE; wr_done may coincide with busy=0.

Optional Feature:
- Macro: DFF_ARB_FIXED_PRIO_EN
- Defined: fixed priority; the lowest-index set req wins, and rr_ptr is neither used nor updated (held at 0).
- Undefined (default): round-robin as specified above.

Decomposition:
- Shared include file (dff_arb_defs.vh) holds:
  - state encodings IDLE=2'd0, GRANT=2'd1, WRITE=2'd2
  - default widths
- Natural sub-module: rr_arbiter.
  - Pure combinational one-hot winner select from req and rr_ptr.
  - Honours DFF_ARB_FIXED_PRIO_EN.
  - Instantiated once.
- Bank storage and FSM remain in the top module.

Test Plan:
- Reset values: assert rst mid-cycle with random inputs -> gnt=0000, busy=0, wr_done=0, rd_data=0 for all rd_addr, all without a clk edge.
- Single request: req=0010, wr_addr[1]=2, wr_data[1]=8'hA5 -> gnt=0010 one cycle after the edge, wr_done two cycles later, rd_addr=2 -> 8'hA5.
- Simultaneous requests, round-robin: req=1111 held, each with a distinct address and data -> grant order 0,1,2,3,0, every 3 cycles; all four registers hold the expected data.
- Same address: req=0101 both targeting address 3, data 8'h11 (req0) and 8'h22 (req2) -> bank[3]=8'h22 at the end.
- Reset mid-operation: assert rst during WRITE for address 1, data 8'hFF -> bank[1]=0, no wr_done, next grant goes to the lowest index.
- Fixed priority: with DFF_ARB_FIXED_PRIO_EN defined and req=1001 held -> requester 0 is granted every time and requester 3 is never granted.

Source files
------------

// File: rtl/dff_bank_arbiter_pkg.sv
// Shared state encoding, default widths and sizing helper for the arbitrated DFF bank.
package dff_bank_arbiter_pkg;

   localparam int unsigned DEF_NREQ  = 4;
   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_AW    = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WRITE = 2'd2
   } arb_state_e;

   // Width of a requester index; never below one bit.
   function automatic int unsigned ptr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_arbiter.sv
// Combinational one-hot winner select from req, scanning upward from rr_ptr with wrap.
// DFF_ARB_FIXED_PRIO_EN selects fixed lowest-index priority and ignores rr_ptr.
module dff_bank_arbiter_rr_arbiter
   import dff_bank_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = DEF_NREQ,
   parameter int unsigned PW   = ptr_w(DEF_NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   rr_ptr,
   output logic [NREQ-1:0] gnt_c,
   output logic [PW-1:0]   winner_c
);

   logic          found;
   logic [PW-1:0] cand;

`ifdef DFF_ARB_FIXED_PRIO_EN
   wire unused_rr_ptr = ^rr_ptr;

   always_comb begin
      gnt_c    = '0;
      winner_c = '0;
      found    = 1'b0;
      cand     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = PW'(k);
         if (!found && req[cand]) begin
            found    = 1'b1;
            winner_c = cand;
         end
      end
      gnt_c[winner_c] = found;
   end
`else
   always_comb begin
      gnt_c    = '0;
      winner_c = '0;
      found    = 1'b0;
      cand     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = PW'((32'(rr_ptr) + k) % NREQ);
         if (!found && req[cand]) begin
            found    = 1'b1;
            winner_c = cand;
         end
      end
      gnt_c[winner_c] = found;
   end
`endif

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter (IDLE -> GRANT -> WRITE) in front of a DFF register bank.
// Define DFF_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module dff_bank_arbiter
   import dff_bank_arbiter_pkg::*;
#(
   parameter int unsigned NREQ  = DEF_NREQ,
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned AW    = DEF_AW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*AW-1:0]    wr_addr,
   input  logic [NREQ*WIDTH-1:0] wr_data,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  wr_done,
   input  logic [AW-1:0]         rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   localparam int unsigned DEPTH = 32'(1) << AW;
   localparam int unsigned PW    = ptr_w(NREQ);

   arb_state_e state, state_nxt;

   logic [WIDTH-1:0] bank [DEPTH];
   logic [PW-1:0]    rr_ptr, rr_ptr_nxt;
   logic [AW-1:0]    hold_addr, hold_addr_nxt;
   logic [WIDTH-1:0] hold_data, hold_data_nxt;
   logic [PW-1:0]    hold_winner, hold_winner_nxt;
   logic [NREQ-1:0]  gnt_nxt;
   logic             busy_nxt;
   logic             wr_done_nxt;
   logic             bank_we;

   logic [NREQ-1:0]  arb_gnt_c;
   logic [PW-1:0]    arb_winner_c;

   dff_bank_arbiter_rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req      (req),
      .rr_ptr   (rr_ptr),
      .gnt_c    (arb_gnt_c),
      .winner_c (arb_winner_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state, registered outputs and holding registers.
   always_comb begin
      state_nxt       = state;
      gnt_nxt         = '0;
      busy_nxt        = 1'b0;
      wr_done_nxt     = 1'b0;
      bank_we         = 1'b0;
      rr_ptr_nxt      = rr_ptr;
      hold_addr_nxt   = hold_addr;
      hold_data_nxt   = hold_data;
      hold_winner_nxt = hold_winner;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt       = GRANT;
               gnt_nxt         = arb_gnt_c;
               busy_nxt        = 1'b1;
               hold_winner_nxt = arb_winner_c;
               hold_addr_nxt   = wr_addr[32'(arb_winner_c)*AW +: AW];
               hold_data_nxt   = wr_data[32'(arb_winner_c)*WIDTH +: WIDTH];
            end
         end
         GRANT: begin
            state_nxt = WRITE;
            busy_nxt  = 1'b1;
         end
         WRITE: begin
            state_nxt   = IDLE;
            bank_we     = 1'b1;
            wr_done_nxt = 1'b1;
`ifndef DFF_ARB_FIXED_PRIO_EN
            rr_ptr_nxt  = PW'((32'(hold_winner) + 1) % NREQ);
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef DFF_ARB_FIXED_PRIO_EN
   wire unused_hold_winner = ^hold_winner;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt         <= '0;
         busy        <= 1'b0;
         wr_done     <= 1'b0;
         rr_ptr      <= '0;
         hold_addr   <= '0;
         hold_data   <= '0;
         hold_winner <= '0;
      end else begin
         gnt         <= gnt_nxt;
         busy        <= busy_nxt;
         wr_done     <= wr_done_nxt;
         rr_ptr      <= rr_ptr_nxt;
         hold_addr   <= hold_addr_nxt;
         hold_data   <= hold_data_nxt;
         hold_winner <= hold_winner_nxt;
      end
   end

   // Register bank; the write lands on the edge leaving WRITE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      end else if (bank_we) begin
         bank[hold_addr] <= hold_data;
      end
   end

   assign rd_data = bank[rd_addr];

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: randomized traffic against a transaction-level model.
module tb_dff_bank_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned AW    = 2;
   localparam int unsigned DEPTH = 1 << AW;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*AW-1:0]    wr_addr = '0;
   logic [NREQ*WIDTH-1:0] wr_data = '0;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic                  wr_done;
   logic [AW-1:0]         rd_addr = '0;
   logic [WIDTH-1:0]      rd_data;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   logic [WIDTH-1:0] exp_bank [DEPTH];
   int               exp_ptr;

   dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .gnt     (gnt),
      .busy    (busy),
      .wr_done (wr_done),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      wr_addr[i*AW +: AW]       = a;
      wr_data[i*WIDTH +: WIDTH] = d;
   endtask

   task automatic scramble();
      for (int i = 0; i < NREQ; i++) set_lane(i, AW'($urandom), WIDTH'($urandom));
   endtask

   function automatic logic [AW-1:0] lane_addr(input int i);
      return wr_addr[i*AW +: AW];
   endfunction

   function automatic logic [WIDTH-1:0] lane_data(input int i);
      return wr_data[i*WIDTH +: WIDTH];
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int w);
      logic [NREQ-1:0] v;
      v = '0;
      if (w >= 0) v[w] = 1'b1;
      return v;
   endfunction

   // Reference winner: first set request scanning from the pointer (or from 0 in fixed mode).
   function automatic int exp_winner(input logic [NREQ-1:0] r);
`ifdef DFF_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
      for (int k = 0; k < NREQ; k++) if (r[(exp_ptr + k) % NREQ]) return (exp_ptr + k) % NREQ;
`endif
      return -1;
   endfunction

   function automatic void model_commit(input int w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      exp_bank[a] = d;
`ifndef DFF_ARB_FIXED_PRIO_EN
      exp_ptr = (w + 1) % NREQ;
`endif
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) exp_bank[i] = '0;
      exp_ptr = 0;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      int w;
      model_reset();
      rst = 1'b1;
      tick();
      tick();
      chk_cnt++;
      if (gnt !== '0 || busy !== 1'b0 || wr_done !== 1'b0)
         $display("FAIL reset_hold gnt=%b busy=%b wr_done=%b want 0/0/0", gnt, busy, wr_done);
      else pass_cnt++;
      rst = 1'b0;
      // Put real data in the bank, then start a second transaction and reset in its GRANT cycle.
      w = int'($urandom_range(NREQ - 1));
      scramble();
      set_lane(w, AW'($urandom), WIDTH'($urandom) | 8'h01);
      req = onehot(w);
      tick();
      req = '0;
      tick();
      tick();
      req = NREQ'($urandom) | 4'b0001;
      scramble();
      tick();
      scramble();
      req = NREQ'($urandom);
      #2 rst = 1'b1;
      #1;
      chk_cnt++;
      if (gnt !== '0 || busy !== 1'b0 || wr_done !== 1'b0)
         $display("FAIL reset_async gnt=%b busy=%b wr_done=%b want 0/0/0", gnt, busy, wr_done);
      else pass_cnt++;
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = AW'(a);
         #1;
         chk_cnt++;
         if (rd_data !== '0) $display("FAIL reset_bank[%0d] got %h want 00", a, rd_data);
         else pass_cnt++;
      end
      tick();
      rst = 1'b0;
      req = '0;
      model_reset();
   endtask

   task automatic test_single();
      logic [NREQ-1:0] r;
      int w;
      r = 4'b0010;
      scramble();
      set_lane(1, 2'd2, 8'hA5);
      req = r;
      w = exp_winner(r);
      tick();
      chk_cnt++;
      if (gnt !== onehot(w) || busy !== 1'b1)
         $display("FAIL single_gnt gnt=%b busy=%b want %b/1", gnt, busy, onehot(w));
      else pass_cnt++;
      req = '0;
      scramble();
      rd_addr = 2'd2;
      tick();
      chk_cnt++;
      if (gnt !== '0 || busy !== 1'b1 || wr_done !== 1'b0 || rd_data !== exp_bank[2])
         $display("FAIL single_write gnt=%b busy=%b wr_done=%b rd=%h want 0/1/0/%h",
                  gnt, busy, wr_done, rd_data, exp_bank[2]);
      else pass_cnt++;
      tick();
      model_commit(w, 2'd2, 8'hA5);
      chk_cnt++;
      if (wr_done !== 1'b1 || busy !== 1'b0 || rd_data !== 8'hA5)
         $display("FAIL single_done wr_done=%b busy=%b rd=%h want 1/0/a5", wr_done, busy, rd_data);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (wr_done !== 1'b0) $display("FAIL single_pulse wr_done=%b want 0", wr_done);
      else pass_cnt++;
   endtask

   task automatic test_round_robin();
      int w;
      do_reset();
      for (int i = 0; i < NREQ; i++) set_lane(i, AW'(i), {4'(i + 1), 4'($urandom)});
      req = '1;
      for (int g = 0; g < 5; g++) begin
         w = exp_winner(req);
         tick();
         chk_cnt++;
         if (gnt !== onehot(w) || wr_done !== 1'b0)
            $display("FAIL rr_gnt%0d gnt=%b wr_done=%b want %b/0", g, gnt, wr_done, onehot(w));
         else pass_cnt++;
         tick();
         chk_cnt++;
         if (gnt !== '0 || busy !== 1'b1) $display("FAIL rr_idle%0d gnt=%b busy=%b want 0/1", g, gnt, busy);
         else pass_cnt++;
         tick();
         model_commit(w, lane_addr(w), lane_data(w));
         chk_cnt++;
         if (wr_done !== 1'b1) $display("FAIL rr_done%0d wr_done=%b want 1", g, wr_done);
         else pass_cnt++;
      end
      req = '0;
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = AW'(a);
         #1;
         chk_cnt++;
         if (rd_data !== exp_bank[a]) $display("FAIL rr_bank[%0d] got %h want %h", a, rd_data, exp_bank[a]);
         else pass_cnt++;
      end
      tick();
   endtask

   task automatic test_same_addr();
      int w;
      do_reset();
      scramble();
      set_lane(0, 2'd3, 8'h11);
      set_lane(2, 2'd3, 8'h22);
      req = 4'b0101;
      for (int g = 0; g < 2; g++) begin
         w = exp_winner(req);
         tick();
         chk_cnt++;
         if (gnt !== onehot(w)) $display("FAIL same_gnt%0d gnt=%b want %b", g, gnt, onehot(w));
         else pass_cnt++;
         req[w] = 1'b0;
         tick();
         tick();
         model_commit(w, lane_addr(w), lane_data(w));
      end
      rd_addr = 2'd3;
      #1;
      chk_cnt++;
      if (rd_data !== exp_bank[3]) $display("FAIL same_bank3 got %h want %h", rd_data, exp_bank[3]);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_reset_mid();
      logic [NREQ-1:0] r;
      int w;
      do_reset();
      scramble();
      set_lane(1, 2'd1, 8'hFF);
      req = 4'b0010;
      tick();
      req = '0;
      tick();
      chk_cnt++;
      if (busy !== 1'b1) $display("FAIL mid_busy busy=%b want 1", busy);
      else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      rd_addr = 2'd1;
      #1;
      chk_cnt++;
      if (rd_data !== '0 || wr_done !== 1'b0 || busy !== 1'b0)
         $display("FAIL mid_abort rd=%h wr_done=%b busy=%b want 00/0/0", rd_data, wr_done, busy);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (wr_done !== 1'b0 || rd_data !== '0)
         $display("FAIL mid_nowrite wr_done=%b rd=%h want 0/00", wr_done, rd_data);
      else pass_cnt++;
      rst = 1'b0;
      model_reset();
      r = NREQ'($urandom) | 4'b1000;
      req = r;
      w = exp_winner(r);
      tick();
      chk_cnt++;
      if (gnt !== (r & -r)) $display("FAIL mid_lowest gnt=%b want %b", gnt, r & -r);
      else pass_cnt++;
      req = '0;
      tick();
      tick();
      model_commit(w, lane_addr(w), lane_data(w));
      chk_cnt++;
      if (wr_done !== 1'b1) $display("FAIL mid_resume wr_done=%b want 1", wr_done);
      else pass_cnt++;
   endtask

`ifdef DFF_ARB_FIXED_PRIO_EN
   task automatic test_fixed_prio();
      do_reset();
      scramble();
      req = 4'b1001;
      for (int g = 0; g < 4; g++) begin
         tick();
         chk_cnt++;
         if (gnt !== 4'b0001) $display("FAIL fixed_gnt%0d gnt=%b want 0001", g, gnt);
         else pass_cnt++;
         tick();
         tick();
      end
      req = '0;
      tick();
      model_reset();
      do_reset();
   endtask
`endif

   task automatic test_random();
      logic [NREQ-1:0] r;
      logic [AW-1:0]   a;
      logic [WIDTH-1:0] d;
      int w;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(3) == 0) begin
            req = '0;
            scramble();
            tick();
            chk_cnt++;
            if (busy !== 1'b0 || gnt !== '0) $display("FAIL rnd_idle%0d busy=%b gnt=%b want 0/0", n, busy, gnt);
            else pass_cnt++;
         end
         r = NREQ'($urandom);
         if (r == '0) r = 4'b0100;
         scramble();
         req = r;
         w = exp_winner(r);
         a = lane_addr(w);
         d = lane_data(w);
         tick();
         chk_cnt++;
         if (gnt !== onehot(w) || busy !== 1'b1)
            $display("FAIL rnd_gnt%0d gnt=%b busy=%b want %b/1", n, gnt, busy, onehot(w));
         else pass_cnt++;
         req = NREQ'($urandom);
         scramble();
         tick();
         rd_addr = a;
         #1;
         chk_cnt++;
         if (rd_data !== exp_bank[a] || wr_done !== 1'b0)
            $display("FAIL rnd_old%0d rd=%h wr_done=%b want %h/0", n, rd_data, wr_done, exp_bank[a]);
         else pass_cnt++;
         req = NREQ'($urandom);
         tick();
         model_commit(w, a, d);
         chk_cnt++;
         if (rd_data !== d || wr_done !== 1'b1 || busy !== 1'b0)
            $display("FAIL rnd_new%0d rd=%h wr_done=%b busy=%b want %h/1/0", n, rd_data, wr_done, busy, d);
         else pass_cnt++;
      end
      req = '0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_same_addr();
      test_reset_mid();
`ifdef DFF_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`endif
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
